// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 4 x 8-bit register file: round-robin among the
// writeback sources, with an optional locked burst that holds the port for one owner.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ARB    | round-robin search from ptr; a requester granted last cycle is masked
// ST_LOCKED | only the owner is served, up to MAX_BURST grants per burst
module regfile_write_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int WORD_LENGTH = 8,
    parameter int ADDR_WIDTH  = 2,
    parameter int MAX_BURST   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           write_reg_en,
    output logic [ADDR_WIDTH-1:0]          write_reg,
    output logic [WORD_LENGTH-1:0]         write_data,
    output logic                           locked
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [3:0]             bcnt_q, bcnt_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic                   en_q, en_d;
    logic [ADDR_WIDTH-1:0]  wreg_q, wreg_d;
    logic [WORD_LENGTH-1:0] wdata_q, wdata_d;

    logic [NUM_REQ-1:0]     elig;
    logic [PTR_W-1:0]       cand;
    logic                   win_vld;
    logic [PTR_W-1:0]       win_idx;
    logic [PTR_W-1:0]       sel;
    logic                   issue;

    logic [ADDR_WIDTH-1:0]  addr_arr [NUM_REQ];
    logic [WORD_LENGTH-1:0] data_arr [NUM_REQ];

    function automatic logic [PTR_W-1:0] add_mod(input logic [PTR_W-1:0] a,
                                                 input logic [PTR_W-1:0] b);
        logic [PTR_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (PTR_W+1)'(NUM_REQ))
            sum = sum - (PTR_W+1)'(NUM_REQ);
        return sum[PTR_W-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            data_arr[i] = req_data[i*WORD_LENGTH +: WORD_LENGTH];
        end
    end

    // Descending scan so the last hit is the first eligible requester from ptr.
    always_comb begin
        elig    = req & ~gnt_q;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int j = NUM_REQ-1; j >= 0; j--) begin
            cand = add_mod(ptr_q, PTR_W'(j));
            if (elig[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        bcnt_d  = bcnt_q;
        gnt_d   = '0;
        en_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        issue   = 1'b0;
        sel     = win_idx;

        case (state_q)
            ST_ARB: begin
                if (win_vld) begin
                    issue = 1'b1;
                    if (req_lock[win_idx]) begin
                        state_d = ST_LOCKED;
                        owner_d = win_idx;
                        bcnt_d  = 4'd1;
                    end else begin
                        ptr_d = add_mod(win_idx, PTR_W'(1));
                    end
                end
            end
            ST_LOCKED: begin
                sel = owner_q;
                if (req[owner_q] && req_lock[owner_q] && (bcnt_q < 4'(MAX_BURST))) begin
                    issue  = 1'b1;
                    bcnt_d = bcnt_q + 4'd1;
                end else begin
                    // Release costs one idle cycle; the owner drops to lowest priority.
                    state_d = ST_ARB;
                    ptr_d   = add_mod(owner_q, PTR_W'(1));
                    bcnt_d  = 4'd0;
                end
            end
            default: state_d = ST_ARB;
        endcase

        if (issue) begin
            gnt_d[sel] = 1'b1;
            en_d       = 1'b1;
            wreg_d     = addr_arr[sel];
            wdata_d    = data_arr[sel];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            bcnt_q  <= '0;
            gnt_q   <= '0;
            en_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            bcnt_q  <= bcnt_d;
            gnt_q   <= gnt_d;
            en_q    <= en_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign gnt          = gnt_q;
    assign write_reg_en = en_q;
    assign write_reg    = wreg_q;
    assign write_data   = wdata_q;
    assign locked       = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic,
// every cycle checked against an integer-level arbitration model.
module tb_regfile_write_arbiter;

    localparam int NR = 3;
    localparam int WL = 8;
    localparam int AW = 2;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_lock;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*WL-1:0]  req_data;
    logic [NR-1:0]     gnt;
    logic              write_reg_en;
    logic [AW-1:0]     write_reg;
    logic [WL-1:0]     write_data;
    logic              locked;

    int n_cmp = 0;
    int n_mis = 0;

    logic [NR-1:0] m_gnt;
    logic          m_en;
    logic [AW-1:0] m_reg;
    logic [WL-1:0] m_data;
    logic          m_locked;
    int            m_ptr;
    int            m_owner;
    int            m_burst;

    logic [WL-1:0] rf [4];

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .NUM_REQ(NR), .WORD_LENGTH(WL), .ADDR_WIDTH(AW), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data), .gnt(gnt),
        .write_reg_en(write_reg_en), .write_reg(write_reg),
        .write_data(write_data), .locked(locked)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gnt = '0; m_en = 1'b0; m_reg = '0; m_data = '0; m_locked = 1'b0;
        m_ptr = 0; m_owner = 0; m_burst = 0;
    endtask

    task automatic model_issue(input int w);
        m_gnt  = NR'(1) << w;
        m_en   = 1'b1;
        m_reg  = req_addr[w*AW +: AW];
        m_data = req_data[w*WL +: WL];
    endtask

    // Next-edge expectation from the inputs as they stand before the edge.
    task automatic model_step();
        int w;
        w = -1;
        if (!m_locked) begin
            for (int k = 0; k < NR; k++)
                if (w < 0 && req[(m_ptr+k)%NR] && !m_gnt[(m_ptr+k)%NR])
                    w = (m_ptr+k)%NR;
            if (w >= 0) begin
                model_issue(w);
                if (req_lock[w]) begin
                    m_locked = 1'b1; m_owner = w; m_burst = 1;
                end else begin
                    m_ptr = (w+1)%NR;
                end
            end else begin
                m_gnt = '0; m_en = 1'b0;
            end
        end else if (req[m_owner] && req_lock[m_owner] && m_burst < MB) begin
            model_issue(m_owner);
            m_burst++;
        end else begin
            m_locked = 1'b0; m_ptr = (m_owner+1)%NR; m_burst = 0;
            m_gnt = '0; m_en = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk(tag, 32'({gnt, write_reg_en, write_reg, write_data, locked}),
                 32'({m_gnt, m_en, m_reg, m_data, m_locked}));
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
        if (write_reg_en) rf[write_reg] = write_data;
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        rst = 1'b1;
    endtask

    initial begin
        int cnt [NR];
        int last [NR];
        int max_gap;
        int lk_cnt;
        logic [31:0] seq;
        logic [15:0] wseq;

        rst = 1'b0; req = '0; req_lock = '0; req_addr = '0; req_data = '0;
        for (int i = 0; i < 4; i++) rf[i] = '0;
        model_reset();
        #7;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Round-robin fairness with all requesters held
        req = 3'b111;
        req_addr = NR*AW'($urandom);
        req_data = NR*WL'($urandom);
        for (int i = 0; i < NR; i++) begin cnt[i] = 0; last[i] = -1; end
        max_gap = 0;
        for (int c = 0; c < 30; c++) begin
            step("rr");
            for (int i = 0; i < NR; i++)
                if (gnt[i]) begin
                    cnt[i]++;
                    if (last[i] >= 0 && c - last[i] > max_gap) max_gap = c - last[i];
                    last[i] = c;
                end
        end
        for (int i = 0; i < NR; i++) chk($sformatf("rr_cnt%0d", i), 32'(cnt[i]), 32'd10);
        chk("rr_gap", 32'(max_gap), 32'd3);

        // Asynchronous reset mid-cycle while grants are flowing
        #2;
        async_reset("async_rst");
        seq = '0;
        for (int c = 0; c < 4; c++) begin
            step("post_rst");
            seq = {seq[28:0], gnt};
        end
        chk("post_rst_order", seq, 32'b001_010_100_001);

        // Single requester self-mask
        req = 3'b010;
        req_addr[3:2] = 2'd2;
        req_data[15:8] = 8'hA5;
        cnt[1] = 0;
        for (int c = 0; c < 8; c++) begin
            step("single");
            if (gnt[1]) begin
                cnt[1]++;
                chk("single_wr", 32'({write_reg, write_data}), 32'({2'd2, 8'hA5}));
            end
        end
        chk("single_cnt", 32'(cnt[1]), 32'd4);

        // Locked burst by requester 2 with requester 0 waiting
        req = '0;
        step("idle1");
        req = 3'b101; req_lock = 3'b100;
        req_data[23:16] = 8'h10;
        seq = '0; lk_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            step("burst");
            seq = {seq[28:0], gnt};
            if (locked) lk_cnt++;
            if (gnt[2]) req_data[23:16] = req_data[23:16] + 8'd1;
        end
        chk("burst_order", seq, 32'b100_100_100_100_000_001);
        chk("burst_locked", 32'(lk_cnt), 32'd4);
        req = '0; req_lock = '0;

        // Early lock drop after two grants
        step("idle2");
        req = 3'b001; req_lock = 3'b001;
        seq = '0;
        step("early"); seq = {seq[28:0], gnt};
        step("early"); seq = {seq[28:0], gnt};
        req = 3'b010; req_lock = 3'b000;
        step("early"); seq = {seq[28:0], gnt};
        step("early"); seq = {seq[28:0], gnt};
        chk("early_order", seq, 32'b001_001_000_010);
        req = '0;

        // Same-address conflict from ptr=0
        @(negedge clk);
        async_reset("rst2");
        for (int i = 0; i < 4; i++) rf[i] = '0;
        req = 3'b011; req_lock = '0;
        req_addr[1:0] = 2'd3; req_addr[3:2] = 2'd3;
        req_data[7:0] = 8'h01; req_data[15:8] = 8'h02;
        wseq = '0;
        for (int c = 0; c < 3; c++) begin
            step("conflict");
            if (write_reg_en) wseq = {wseq[7:0], write_data};
            if (gnt[0]) req[0] = 1'b0;
            if (gnt[1]) req[1] = 1'b0;
        end
        chk("conflict_order", 32'(wseq), 32'h0102);
        chk("conflict_rf3", 32'(rf[3]), 32'h02);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            req      = NR'($urandom);
            req_lock = NR'($urandom) & NR'($urandom) | ((c % 37 < 12) ? req : '0);
            req_addr = (NR*AW)'($urandom);
            req_data = (NR*WL)'($urandom);
            if ($urandom_range(0, 79) == 0) async_reset("rand_rst");
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
